// File: rtl/perf_miss_counter_bank_pkg.sv
// Shared types and constants for the performance miss counter bank.
package perf_miss_counter_bank_pkg;

   // Native machine word; used for WIDTH = 16 instantiations.
   typedef logic [15:0] lc3b_word;

   // Values for the SATURATE parameter.
   localparam int unsigned PERF_WRAP = 0;
   localparam int unsigned PERF_SAT  = 1;

   // Conventional channel indices for cause attribution.
   localparam int unsigned PERF_CH_READ  = 0;
   localparam int unsigned PERF_CH_WRITE = 1;

endpackage

// File: rtl/perf_miss_counter_bank_cell.sv
// One event counter with sticky overflow and wrap/saturate behaviour.
module perf_counter_cell
   import perf_miss_counter_bank_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned SATURATE = PERF_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt,
   output logic             overflow
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Next count: clear beats increment; all-ones rolls over or holds.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + WIDTH'(1);
         end else begin
            ovf_d = 1'b1;
            cnt_d = (SATURATE == PERF_SAT) ? '1 : '0;
         end
      end
   end

   // Counter and overflow registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt      = cnt_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/perf_miss_counter_bank.sv
// Bank of cause-attributed memory-request counters with a freezable snapshot view.
module perf_miss_counter_bank
   import perf_miss_counter_bank_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned SATURATE = PERF_WRAP,
   localparam int unsigned SEL_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic              pmem_read,
   input  logic [NUM_CH-1:0] cause,
   input  logic              freeze,
   input  logic [SEL_W-1:0]  sel,
   output logic [WIDTH-1:0]  count_out,
   output logic [NUM_CH-1:0] overflow
);

   logic                          pmem_q, pmem_d;
   logic                          pmem_edge_c;
   logic [NUM_CH-1:0]             inc_c;
   logic [NUM_CH-1:0][WIDTH-1:0]  cnt_c;
   logic [NUM_CH-1:0][WIDTH-1:0]  shadow_q, shadow_d;

   // Rising-edge detect on the request level; history tracks even when disabled or clearing.
   always_comb begin
      pmem_d      = pmem_read;
      pmem_edge_c = pmem_read & ~pmem_q;
   end

   // Fixed-priority attribution: lowest-index asserted cause wins the event.
   always_comb begin
      logic found;
      inc_c = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && cause[i] && pmem_edge_c && enable) begin
            inc_c[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   // Per-channel counters.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
      perf_counter_cell #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .inc      (inc_c[g]),
         .cnt      (cnt_c[g]),
         .overflow (overflow[g])
      );
   end

   // Snapshot follows the live counts unless frozen.
   always_comb begin
      shadow_d = freeze ? shadow_q : cnt_c;
   end

   // Edge-detect history and snapshot registers; history resets high so a held level is not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         pmem_q   <= 1'b1;
         shadow_q <= '0;
      end else begin
         pmem_q   <= pmem_d;
         shadow_q <= shadow_d;
      end
   end

   // Snapshot read mux; unmatched select values read as zero.
   always_comb begin
      count_out = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == SEL_W'(i)) count_out = shadow_q[i];
      end
   end

endmodule
